// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO register pair.
// Start/busy/done handshake, signed/unsigned ops, cancel and direct MTHI/MTLO writes.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t state, state_nx;

   logic             is_arith, is_div, is_signed, is_mthi, is_mtlo;
   logic             a_neg, b_neg, b_zero;
   logic [WIDTH-1:0] a_mag, b_mag;

   logic             accept, step, finish, wr_mthi, wr_mtlo;

   logic [CNT_W-1:0] cnt;
   logic             op_div, op_dz, neg_q, neg_r;
   logic [WIDTH-1:0] work_a;  // multiplier / quotient / raw dividend on div-by-zero
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] acc;     // upper partial product / partial remainder

   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic               q_bit;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   always_comb begin
      is_arith  = ~op[2];
      is_div    = op[1];
      is_signed = ~op[0];
      is_mthi   = (op == 3'b100);
      is_mtlo   = (op == 3'b101);
      a_neg     = is_signed & a[WIDTH-1];
      b_neg     = is_signed & b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
      b_zero    = (b == '0);
   end

   // Datapath step results; the borrow out of the W+1 bit subtract selects restore.
   always_comb begin
      mul_sum   = {1'b0, acc} + {1'b0, (work_a[0] ? mag_b : {WIDTH{1'b0}})};
      div_shift = {acc, work_a[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mag_b};
      q_bit     = ~div_diff[WIDTH];
      prod      = {acc, work_a};
      prod_fix  = neg_q ? -prod : prod;
      quo_fix   = neg_q ? -work_a : work_a;
      rem_fix   = neg_r ? -acc : acc;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      step     = 1'b0;
      finish   = 1'b0;
      wr_mthi  = 1'b0;
      wr_mtlo  = 1'b0;
      busy     = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start && !cancel) begin
               if (is_arith) begin
                  accept   = 1'b1;
                  state_nx = (is_div && b_zero) ? S_FIX : S_RUN;
               end else if (is_mthi) begin
                  wr_mthi = 1'b1;
               end else if (is_mtlo) begin
                  wr_mtlo = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (cancel) begin
               state_nx = S_IDLE;
            end else begin
               step = 1'b1;
               if (cnt == CNT_W'(1)) state_nx = S_FIX;
            end
         end
         S_FIX: begin
            state_nx = S_IDLE;
            if (!cancel) finish = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         cnt         <= '0;
         op_div      <= 1'b0;
         op_dz       <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         work_a      <= '0;
         mag_b       <= '0;
         acc         <= '0;
      end else begin
         done <= finish;
         if (accept) begin
            op_div <= is_div;
            op_dz  <= is_div & b_zero;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= CNT_W'(WIDTH);
            work_a <= (is_div && b_zero) ? a : a_mag;
            mag_b  <= b_mag;
            acc    <= '0;
         end
         if (step) begin
            cnt <= cnt - 1'b1;
            if (op_div) begin
               acc    <= q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
               work_a <= {work_a[WIDTH-2:0], q_bit};
            end else begin
               acc    <= mul_sum[WIDTH:1];
               work_a <= {mul_sum[0], work_a[WIDTH-1:1]};
            end
         end
         if (wr_mthi) hi <= a;
         if (wr_mtlo) lo <= a;
         if (finish) begin
            if (op_dz) begin
               hi          <= work_a;
               lo          <= '1;
               div_by_zero <= 1'b1;
            end else if (op_div) begin
               hi          <= rem_fix;
               lo          <= quo_fix;
               div_by_zero <= 1'b0;
            end else begin
               {hi, lo}    <= prod_fix;
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule
